// File: rtl/pipe_ctrl.sv
// Pipeline controller: RAW/WAW scoreboard, decode stall, redirect flush and halt/drain/resume sequencing.
// Latency: issue/stall/flush are combinational from inputs and state; scoreboard, FSM, halted and stall count update on the next edge.
// Backpressure: decode holds while hazard, EX busy, flush or a non-RUN state is present; nothing here is ever back-pressured itself.
module pipe_ctrl #(
  parameter int NREG         = 32,
  parameter int AW           = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid_i,
  input  logic [AW-1:0] id_rs1_i,
  input  logic [AW-1:0] id_rs2_i,
  input  logic          id_rs1_en_i,
  input  logic          id_rs2_en_i,
  input  logic [AW-1:0] id_rd_i,
  input  logic          id_rd_en_i,
  input  logic          ex_busy_i,
  input  logic          ex_redirect_i,
  input  logic          wb_valid_i,
  input  logic [AW-1:0] wb_rd_i,
  input  logic          halt_req_i,
  input  logic          resume_i,
  output logic          id_issue_o,
  output logic          id_stall_o,
  output logic          flush_o,
  output logic          halted_o,
  output logic [31:0]   stall_cnt_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  // A single-cycle flush needs no FLUSH state: flush_o follows the redirect directly.
  localparam bit         USE_FLUSH    = (FLUSH_CYCLES > 1);
  localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);

  state_t          state_q, state_d;
  logic [3:0]      fcnt_q, fcnt_d;
  logic [NREG-1:0] pend_q, pend_d;
  logic            halt_blk_q, halt_blk_d;
  logic [31:0]     stall_cnt_q;
  logic            hazard;
  logic            halt_go;

  // No write-through: a WB clear this cycle does not release the hazard until next cycle.
  assign hazard = (id_rs1_en_i & pend_q[id_rs1_i]) |
                  (id_rs2_en_i & pend_q[id_rs2_i]) |
                  (id_rd_en_i  & pend_q[id_rd_i]);

  assign flush_o     = ex_redirect_i | (state_q == FLUSH);
  assign id_stall_o  = id_valid_i & (hazard | ex_busy_i | flush_o | (state_q != RUN));
  assign id_issue_o  = id_valid_i & ~id_stall_o;
  assign halted_o    = (state_q == HALTED);
  assign stall_cnt_o = stall_cnt_q;

  // A halt request left high across a resume must be dropped and re-raised before it counts again.
  assign halt_go = halt_req_i & ~halt_blk_q;

  // Next-state logic for the run/flush/drain/halt sequencer and its flush counter.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    halt_blk_d = halt_req_i ? halt_blk_q : 1'b0;
    case (state_q)
      RUN: begin
        if (ex_redirect_i && USE_FLUSH) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_RELOAD;
        end else if (halt_go) begin
          state_d = DRAIN;
        end
      end
      FLUSH: begin
        if (ex_redirect_i) begin
          fcnt_d = FLUSH_RELOAD;
        end else if (fcnt_q <= 4'd1) begin
          fcnt_d  = 4'd0;
          state_d = halt_go ? DRAIN : RUN;
        end else begin
          fcnt_d = fcnt_q - 4'd1;
        end
      end
      DRAIN: begin
        if ((pend_q == '0) && !ex_busy_i) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        if (resume_i) begin
          state_d    = RUN;
          halt_blk_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Scoreboard update: retire clears, issue sets, set wins on the same index, r0 never tracked.
  always_comb begin
    pend_d = pend_q;
    if (wb_valid_i) begin
      pend_d[wb_rd_i] = 1'b0;
    end
    if (id_issue_o && id_rd_en_i) begin
      pend_d[id_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // State, scoreboard and saturating stall counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      fcnt_q      <= 4'd0;
      pend_q      <= '0;
      halt_blk_q  <= 1'b0;
      stall_cnt_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      pend_q     <= pend_d;
      halt_blk_q <= halt_blk_d;
      if (id_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: per-cycle vector table with hand-derived expectations.
// Each vector is driven just after a rising edge; expectations go through a queue and are checked on the falling edge.
// Covers reset state, RAW stall, r0 and set-wins, EX busy, redirect and re-redirect, halt/drain/resume, reset during flush.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i, wb_rd_i;
  logic        id_rs1_en_i, id_rs2_en_i, id_rd_en_i;
  logic        ex_busy_i, ex_redirect_i, wb_valid_i, halt_req_i, resume_i;
  logic        id_issue_o, id_stall_o, flush_o, halted_o;
  logic [31:0] stall_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.NREG(32), .AW(5), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_rs1_en_i(id_rs1_en_i), .id_rs2_en_i(id_rs2_en_i),
    .id_rd_i(id_rd_i), .id_rd_en_i(id_rd_en_i),
    .ex_busy_i(ex_busy_i), .ex_redirect_i(ex_redirect_i),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i),
    .halt_req_i(halt_req_i), .resume_i(resume_i),
    .id_issue_o(id_issue_o), .id_stall_o(id_stall_o),
    .flush_o(flush_o), .halted_o(halted_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic       rst, vld;
    logic [4:0] rs1; logic rs1e;
    logic [4:0] rs2; logic rs2e;
    logic [4:0] rd;  logic rde;
    logic       busy, redir, wbv;
    logic [4:0] wbrd;
    logic       halt, resume;
    logic       e_issue, e_stall, e_flush, e_halted;
    int         e_cnt;   // -1: stall count not checked on this cycle
  } vec_t;

  typedef struct {
    int   idx;
    logic e_issue, e_stall, e_flush, e_halted;
    int   e_cnt;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(
    input logic r, input logic v,
    input int rs1, input logic rs1e, input int rs2, input logic rs2e,
    input int rd, input logic rde,
    input logic busy, input logic redir, input logic wbv, input int wbrd,
    input logic halt, input logic resume,
    input logic ei, input logic es, input logic ef, input logic eh, input int ecnt);
    vec_t t;
    t.rst = r; t.vld = v;
    t.rs1 = 5'(rs1); t.rs1e = rs1e; t.rs2 = 5'(rs2); t.rs2e = rs2e;
    t.rd = 5'(rd); t.rde = rde;
    t.busy = busy; t.redir = redir; t.wbv = wbv; t.wbrd = 5'(wbrd);
    t.halt = halt; t.resume = resume;
    t.e_issue = ei; t.e_stall = es; t.e_flush = ef; t.e_halted = eh;
    t.e_cnt = ecnt;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @vec %0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst           = t.rst;
    id_valid_i    = t.vld;
    id_rs1_i      = t.rs1;  id_rs1_en_i = t.rs1e;
    id_rs2_i      = t.rs2;  id_rs2_en_i = t.rs2e;
    id_rd_i       = t.rd;   id_rd_en_i  = t.rde;
    ex_busy_i     = t.busy;
    ex_redirect_i = t.redir;
    wb_valid_i    = t.wbv;  wb_rd_i     = t.wbrd;
    halt_req_i    = t.halt;
    resume_i      = t.resume;
  endtask

  initial begin
    exp_t e;
    //                r  v rs1 e rs2 e rd e bsy rdr wbv wbrd hlt res | iss stl fl hlt cnt
    // reset state
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));
    // RAW: issue rd=5, then rs1=5 stalls until the cycle after WB clears r5
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 1, 5, 0, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4));
    // r0: writing r0 never creates a hazard
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 4));
    // set wins: issue to r7 with a same-cycle WB clear of r7
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 7, 1, 0, 0, 1, 7, 0, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0,   0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 5));
    // EX busy for 5 cycles, hazard-free instruction
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 5));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 10));
    // single redirect: flush for 2 cycles, issue on the third
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 12));
    // back-to-back redirects extend the flush by one cycle
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 1, 1, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 15));
    // halt with r3 and r9 pending; drain, halt, resume while request still high
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, 15));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 0, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 1, 0, 1, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 1, -1));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 21));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, -1));
    // reset during FLUSH with r4 pending
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, -1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0,   0, 0, 1, 0, -1));
    vecs.push_back(mk(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 21));
    vecs.push_back(mk(0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0));

    drive(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1));
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      e.idx      = i;
      e.e_issue  = vecs[i].e_issue;
      e.e_stall  = vecs[i].e_stall;
      e.e_flush  = vecs[i].e_flush;
      e.e_halted = vecs[i].e_halted;
      e.e_cnt    = vecs[i].e_cnt;
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty @vec %0d", i);
      end else begin
        e = sb.pop_front();
        chk("id_issue_o", e.idx, 32'(id_issue_o), 32'(e.e_issue));
        chk("id_stall_o", e.idx, 32'(id_stall_o), 32'(e.e_stall));
        chk("flush_o",    e.idx, 32'(flush_o),    32'(e.e_flush));
        chk("halted_o",   e.idx, 32'(halted_o),   32'(e.e_halted));
        if (e.e_cnt >= 0)
          chk("stall_cnt_o", e.idx, stall_cnt_o, 32'(e.e_cnt));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
